cmd_fifo_arbiter: RTL and testbench

Shares the single command/response async-FIFO pair (90 MHz side) between up to four test masters. Arbitrates write/read commands into the 17-bit command FIFO, records the issuing master of every read in an internal tag queue, and steers each 8-bit response back to the master that asked for it. Responses return in command order, so a FIFO of master IDs is sufficient.

---
 rtl/cmd_fifo_arbiter_pkg.sv | 44 ++++
 rtl/cmd_fifo_arbiter_tag_queue.sv | 87 ++++++++
 rtl/cmd_fifo_arbiter.sv | 245 ++++++++++++++++++++++++
 tb/tb_cmd_fifo_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_fifo_arbiter_pkg.sv
// cmd_fifo_arbiter_pkg
// Shared definitions for the command/response FIFO arbiter:
//   - command word layout (17 bits: op, 8-bit address, 8-bit write data)
//   - op-code constants
//   - state encodings for the command and response FSMs
//   - make_cmd helper to assemble a command word from its fields
package cmd_fifo_arbiter_pkg;

    localparam int CMD_W    = 17;
    localparam int RESP_W   = 8;
    localparam int OP_BIT   = 16;
    localparam int ADDR_MSB = 15;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        RSP_IDLE    = 2'd0,
        RSP_WAIT    = 2'd1,
        RSP_CAPTURE = 2'd2
    } rsp_state_e;

    function automatic logic [CMD_W-1:0] make_cmd(
        input logic                       op,
        input logic [ADDR_MSB-ADDR_LSB:0] addr,
        input logic [DATA_MSB-DATA_LSB:0] wdata
    );
        logic [CMD_W-1:0] cmd;
        cmd                    = '0;
        cmd[OP_BIT]            = op;
        cmd[ADDR_MSB:ADDR_LSB] = addr;
        cmd[DATA_MSB:DATA_LSB] = wdata;
        return cmd;
    endfunction

endpackage

// File: rtl/cmd_fifo_arbiter_tag_queue.sv
// cmd_fifo_arbiter_tag_queue
// Small synchronous FIFO holding the master ID of every outstanding read.
// Responses come back in command order, so the head entry always names
// the owner of the next response.
// Ports:
//   clk, rst      clock, synchronous active-high reset (empties the queue)
//   push_i        enqueue push_data_i (ignored when full)
//   push_data_i   master ID to enqueue
//   pop_i         dequeue head (ignored when empty)
//   head_o        master ID at the head
//   count_o       number of entries, 0..DEPTH
//   full_o        count_o == DEPTH
//   empty_o       count_o == 0
module cmd_fifo_arbiter_tag_queue
    import cmd_fifo_arbiter_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two; a push and
    // pop in the same cycle leave the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/cmd_fifo_arbiter.sv
// cmd_fifo_arbiter
// Shares one command FIFO (17-bit words) and one response FIFO (8-bit)
// between NUM_MASTERS test masters. Commands are arbitrated one per two
// cycles; each read's master ID is queued so its response can be steered
// back to the right master.
// Configuration macro: CMD_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority, lowest eligible master index wins
//   undefined -> round-robin starting after the last winner
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   m_req_valid       per-master request, held with data until accepted
//   m_req_data        master i word at [17i+16:17i]
//   m_req_ready       one-cycle accept pulse to the winner
//   m_resp_valid      one-cycle response pulse to the owning master
//   m_resp_data       response byte
//   cmd_fifo_wr_en    command FIFO write strobe
//   cmd_fifo_data     command word
//   cmd_fifo_full     command FIFO full
//   resp_fifo_rd_en   response FIFO read strobe
//   resp_fifo_data    response data, valid the cycle after rd_en
//   resp_fifo_empty   response FIFO empty
//   busy              command in flight or reads outstanding
//   resp_orphan_err   sticky: response arrived with no outstanding read
module cmd_fifo_arbiter
    import cmd_fifo_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int TAG_DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_MASTERS-1:0]       m_req_valid,
    input  logic [CMD_W*NUM_MASTERS-1:0] m_req_data,
    output logic [NUM_MASTERS-1:0]       m_req_ready,
    output logic [NUM_MASTERS-1:0]       m_resp_valid,
    output logic [RESP_W-1:0]            m_resp_data,
    output logic                         cmd_fifo_wr_en,
    output logic [CMD_W-1:0]             cmd_fifo_data,
    input  logic                         cmd_fifo_full,
    output logic                         resp_fifo_rd_en,
    input  logic [RESP_W-1:0]            resp_fifo_data,
    input  logic                         resp_fifo_empty,
    output logic                         busy,
    output logic                         resp_orphan_err
);

    localparam int ID_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

    arb_state_e               arb_state_q, arb_state_d;
    logic [CMD_W-1:0]         cmd_data_q, cmd_data_d;
    logic                     cmd_wr_en_q, cmd_wr_en_d;
    logic [NUM_MASTERS-1:0]   req_ready_q, req_ready_d;
`ifndef CMD_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]          rr_q, rr_d;
`endif

    rsp_state_e               rsp_state_q, rsp_state_d;
    logic                     rd_en_q, rd_en_d;
    logic [NUM_MASTERS-1:0]   resp_valid_q, resp_valid_d;
    logic [RESP_W-1:0]        resp_data_q, resp_data_d;
    logic                     orphan_q, orphan_d;

    logic [NUM_MASTERS-1:0]   eligible;
    logic                     grant_found;
    logic [ID_W-1:0]          grant_id;
    logic [CMD_W-1:0]         grant_word;

    logic                     tag_push;
    logic                     tag_pop;
    logic [ID_W-1:0]          tag_head;
    logic [CNT_W-1:0]         tag_count;
    logic                     tag_full;
    logic                     tag_empty;

    cmd_fifo_arbiter_tag_queue #(
        .WIDTH (ID_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_queue (
        .clk         (clk),
        .rst         (rst),
        .push_i      (tag_push),
        .push_data_i (grant_id),
        .pop_i       (tag_pop),
        .head_o      (tag_head),
        .count_o     (tag_count),
        .full_o      (tag_full),
        .empty_o     (tag_empty)
    );

    // A read can only be accepted while there is room to remember its
    // owner; writes never need a tag and so are never held off.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            eligible[i] = m_req_valid[i] &&
                          ((m_req_data[i*CMD_W + OP_BIT] == OP_WRITE) || !tag_full);
        end
    end

    // Winner selection among eligible masters.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
`ifdef CMD_ARB_FIXED_PRIO_EN
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (eligible[ID_W'(i)]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(i);
            end
        end
`else
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            int              idx;
            logic [ID_W-1:0] cand;
            idx = int'(rr_q) + k;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            cand = ID_W'(idx);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
`endif
        grant_word = m_req_data[int'(grant_id)*CMD_W +: CMD_W];
    end

    // Command FSM: grant in ARB_IDLE, then spend one cycle in ARB_ISSUE so
    // the winner can drop or advance its request before the next round.
    always_comb begin
        arb_state_d = arb_state_q;
        cmd_data_d  = cmd_data_q;
        cmd_wr_en_d = 1'b0;
        req_ready_d = '0;
        tag_push    = 1'b0;
`ifndef CMD_ARB_FIXED_PRIO_EN
        rr_d        = rr_q;
`endif
        case (arb_state_q)
            ARB_IDLE: begin
                if (!cmd_fifo_full && grant_found) begin
                    cmd_data_d            = grant_word;
                    cmd_wr_en_d           = 1'b1;
                    req_ready_d[grant_id] = 1'b1;
                    tag_push              = (grant_word[OP_BIT] == OP_READ);
`ifndef CMD_ARB_FIXED_PRIO_EN
                    rr_d                  = grant_id;
`endif
                    arb_state_d           = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                arb_state_d = ARB_IDLE;
            end
            default: begin
                arb_state_d = ARB_IDLE;
            end
        endcase
    end

    // Master 0 wins first out of reset, so the pointer starts at the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            arb_state_q <= ARB_IDLE;
            cmd_data_q  <= '0;
            cmd_wr_en_q <= 1'b0;
            req_ready_q <= '0;
`ifndef CMD_ARB_FIXED_PRIO_EN
            rr_q        <= ID_W'(NUM_MASTERS - 1);
`endif
        end else begin
            arb_state_q <= arb_state_d;
            cmd_data_q  <= cmd_data_d;
            cmd_wr_en_q <= cmd_wr_en_d;
            req_ready_q <= req_ready_d;
`ifndef CMD_ARB_FIXED_PRIO_EN
            rr_q        <= rr_d;
`endif
        end
    end

    // Response FSM: pop the FIFO, wait a cycle for its data, then hand the
    // byte to the master at the head of the tag queue. A response with no
    // outstanding read is flagged and left in the FIFO.
    always_comb begin
        rsp_state_d  = rsp_state_q;
        rd_en_d      = 1'b0;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        orphan_d     = orphan_q;
        tag_pop      = 1'b0;
        case (rsp_state_q)
            RSP_IDLE: begin
                if (!resp_fifo_empty) begin
                    if (!tag_empty) begin
                        rd_en_d     = 1'b1;
                        rsp_state_d = RSP_WAIT;
                    end else begin
                        orphan_d = 1'b1;
                    end
                end
            end
            RSP_WAIT: begin
                rsp_state_d = RSP_CAPTURE;
            end
            RSP_CAPTURE: begin
                resp_data_d            = resp_fifo_data;
                resp_valid_d[tag_head] = 1'b1;
                tag_pop                = 1'b1;
                rsp_state_d            = RSP_IDLE;
            end
            default: begin
                rsp_state_d = RSP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_state_q  <= RSP_IDLE;
            rd_en_q      <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            orphan_q     <= 1'b0;
        end else begin
            rsp_state_q  <= rsp_state_d;
            rd_en_q      <= rd_en_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            orphan_q     <= orphan_d;
        end
    end

    assign m_req_ready     = req_ready_q;
    assign cmd_fifo_wr_en  = cmd_wr_en_q;
    assign cmd_fifo_data   = cmd_data_q;
    assign resp_fifo_rd_en = rd_en_q;
    assign m_resp_valid    = resp_valid_q;
    assign m_resp_data     = resp_data_q;
    assign resp_orphan_err = orphan_q;
    assign busy            = (arb_state_q != ARB_IDLE) || (tag_count != '0);

endmodule

// File: tb/tb_cmd_fifo_arbiter.sv
// tb_cmd_fifo_arbiter
// Directed bench for cmd_fifo_arbiter (NUM_MASTERS=2, TAG_DEPTH=8). The
// response FIFO is a small behavioural model: entries pushed by the tests,
// popped on rd_en with data presented the following cycle.
module tb_cmd_fifo_arbiter;
    import cmd_fifo_arbiter_pkg::*;

    localparam int NM = 2;
    localparam int TD = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NM-1:0]        m_req_valid;
    logic [CMD_W*NM-1:0]  m_req_data;
    logic [NM-1:0]        m_req_ready;
    logic [NM-1:0]        m_resp_valid;
    logic [7:0]           m_resp_data;
    logic                 cmd_fifo_wr_en;
    logic [CMD_W-1:0]     cmd_fifo_data;
    logic                 cmd_fifo_full;
    logic                 resp_fifo_rd_en;
    logic [7:0]           resp_fifo_data = 8'h00;
    logic                 resp_fifo_empty;
    logic                 busy;
    logic                 resp_orphan_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] resp_mem [16];
    int         resp_wr_cnt = 0;
    int         resp_rd_cnt = 0;

    always #5 clk = ~clk;

    cmd_fifo_arbiter #(
        .NUM_MASTERS (NM),
        .TAG_DEPTH   (TD)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .m_req_valid     (m_req_valid),
        .m_req_data      (m_req_data),
        .m_req_ready     (m_req_ready),
        .m_resp_valid    (m_resp_valid),
        .m_resp_data     (m_resp_data),
        .cmd_fifo_wr_en  (cmd_fifo_wr_en),
        .cmd_fifo_data   (cmd_fifo_data),
        .cmd_fifo_full   (cmd_fifo_full),
        .resp_fifo_rd_en (resp_fifo_rd_en),
        .resp_fifo_data  (resp_fifo_data),
        .resp_fifo_empty (resp_fifo_empty),
        .busy            (busy),
        .resp_orphan_err (resp_orphan_err)
    );

    // Response FIFO model; reset flushes it along with the design.
    assign resp_fifo_empty = (resp_wr_cnt == resp_rd_cnt);

    always @(posedge clk) begin
        if (rst) begin
            resp_rd_cnt <= resp_wr_cnt;
        end else if (resp_fifo_rd_en && (resp_rd_cnt != resp_wr_cnt)) begin
            resp_fifo_data <= resp_mem[4'(resp_rd_cnt)];
            resp_rd_cnt    <= resp_rd_cnt + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_resp(input logic [7:0] b);
        resp_mem[4'(resp_wr_cnt)] = b;
        resp_wr_cnt = resp_wr_cnt + 1;
    endtask

    task automatic do_reset;
        rst           = 1'b1;
        m_req_valid   = '0;
        m_req_data    = '0;
        cmd_fifo_full = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (cmd_fifo_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en: got %b expected 0", cmd_fifo_wr_en); end
        checks++; if (m_req_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 00", m_req_ready); end
        checks++; if (m_resp_valid !== 2'b00) begin errors++; $display("[TB] FAIL reset_resp_valid: got %b expected 00", m_resp_valid); end
        checks++; if (resp_fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_en: got %b expected 0", resp_fifo_rd_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (resp_orphan_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_orphan: got %b expected 0", resp_orphan_err); end
        checks++; if (cmd_fifo_data !== 17'h00000) begin errors++; $display("[TB] FAIL reset_cmd_data: got %h expected 00000", cmd_fifo_data); end
        checks++; if (m_resp_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_resp_data: got %h expected 00", m_resp_data); end
    endtask

    task automatic test_write_read;
        do_reset();
        m_req_data[16:0] = make_cmd(OP_WRITE, 8'h10, 8'h6A);
        m_req_valid      = 2'b01;
        tick();
        checks++; if (cmd_fifo_wr_en !== 1'b1) begin errors++; $display("[TB] FAIL wr_wr_en: got %b expected 1", cmd_fifo_wr_en); end
        checks++; if (m_req_ready !== 2'b01) begin errors++; $display("[TB] FAIL wr_ready: got %b expected 01", m_req_ready); end
        checks++; if (cmd_fifo_data !== 17'h1106A) begin errors++; $display("[TB] FAIL wr_cmd_data: got %h expected 1106a", cmd_fifo_data); end
        m_req_data[16:0] = make_cmd(OP_READ, 8'h10, 8'h00);
        tick();
        checks++; if (cmd_fifo_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL issue_gap: got %b expected 0", cmd_fifo_wr_en); end
        tick();
        checks++; if (cmd_fifo_wr_en !== 1'b1) begin errors++; $display("[TB] FAIL rd_wr_en: got %b expected 1", cmd_fifo_wr_en); end
        checks++; if (cmd_fifo_data !== 17'h01000) begin errors++; $display("[TB] FAIL rd_cmd_data: got %h expected 01000", cmd_fifo_data); end
        checks++; if (m_req_ready !== 2'b01) begin errors++; $display("[TB] FAIL rd_ready: got %b expected 01", m_req_ready); end
        m_req_valid = 2'b00;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rd_busy: got %b expected 1", busy); end
        push_resp(8'h6A);
        tick();
        checks++; if (resp_fifo_rd_en !== 1'b1) begin errors++; $display("[TB] FAIL rd_en_pulse: got %b expected 1", resp_fifo_rd_en); end
        tick();
        checks++; if (resp_fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL rd_en_single: got %b expected 0", resp_fifo_rd_en); end
        tick();
        checks++; if (m_resp_valid !== 2'b01) begin errors++; $display("[TB] FAIL resp_valid: got %b expected 01", m_resp_valid); end
        checks++; if (m_resp_data !== 8'h6A) begin errors++; $display("[TB] FAIL resp_data: got %h expected 6a", m_resp_data); end
        tick();
        checks++; if (m_resp_valid !== 2'b00) begin errors++; $display("[TB] FAIL resp_pulse_end: got %b expected 00", m_resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_round_robin;
        logic             exp_wr;
        logic [1:0]       exp_ready;
        logic [CMD_W-1:0] exp_data;
        do_reset();
        m_req_data[16:0]  = make_cmd(OP_WRITE, 8'h11, 8'h01);
        m_req_data[33:17] = make_cmd(OP_WRITE, 8'h22, 8'h02);
        m_req_valid       = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_wr    = (k % 2) == 1;
            exp_ready = !exp_wr ? 2'b00 : ((k % 4) == 1 ? 2'b01 : 2'b10);
            exp_data  = ((k % 4) == 1) ? 17'h11101 : 17'h12202;
            checks++; if (cmd_fifo_wr_en !== exp_wr) begin errors++; $display("[TB] FAIL rr_wr_en[%0d]: got %b expected %b", k, cmd_fifo_wr_en, exp_wr); end
            checks++; if (m_req_ready !== exp_ready) begin errors++; $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", k, m_req_ready, exp_ready); end
            if (exp_wr) begin
                checks++; if (cmd_fifo_data !== exp_data) begin errors++; $display("[TB] FAIL rr_data[%0d]: got %h expected %h", k, cmd_fifo_data, exp_data); end
            end
        end
        m_req_valid = 2'b00;
        tick();
    endtask

    task automatic test_full_backpressure;
        do_reset();
        cmd_fifo_full    = 1'b1;
        m_req_data[16:0] = make_cmd(OP_WRITE, 8'h20, 8'h33);
        m_req_valid      = 2'b01;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++; if (cmd_fifo_wr_en !== 1'b0 || m_req_ready !== 2'b00) begin errors++; $display("[TB] FAIL full_hold[%0d]: got wr_en=%b ready=%b expected 0/00", k, cmd_fifo_wr_en, m_req_ready); end
        end
        cmd_fifo_full = 1'b0;
        tick();
        checks++; if (cmd_fifo_wr_en !== 1'b1) begin errors++; $display("[TB] FAIL full_release_wr_en: got %b expected 1", cmd_fifo_wr_en); end
        checks++; if (m_req_ready !== 2'b01) begin errors++; $display("[TB] FAIL full_release_ready: got %b expected 01", m_req_ready); end
        checks++; if (cmd_fifo_data !== 17'h12033) begin errors++; $display("[TB] FAIL full_release_data: got %h expected 12033", cmd_fifo_data); end
        m_req_valid = 2'b00;
        tick();
    endtask

    task automatic test_interleaved_reads;
        int         ids [4];
        logic [7:0] rdat [4];
        int         got;
        logic [1:0] exp_v;
        ids  = '{0, 1, 1, 0};
        rdat = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            m_req_data[ids[i]*CMD_W +: CMD_W] = make_cmd(OP_READ, 8'(8'h40 + i), 8'h00);
            m_req_valid = 2'(1 << ids[i]);
            tick();
            exp_v = 2'(1 << ids[i]);
            checks++; if (m_req_ready !== exp_v) begin errors++; $display("[TB] FAIL il_ready[%0d]: got %b expected %b", i, m_req_ready, exp_v); end
            m_req_valid = 2'b00;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            push_resp(rdat[i]);
        end
        got = 0;
        for (int c = 0; c < 60 && got < 4; c++) begin
            tick();
            if (m_resp_valid !== 2'b00) begin
                exp_v = 2'(1 << ids[got]);
                checks++; if (m_resp_valid !== exp_v) begin errors++; $display("[TB] FAIL il_owner[%0d]: got %b expected %b", got, m_resp_valid, exp_v); end
                checks++; if (m_resp_data !== rdat[got]) begin errors++; $display("[TB] FAIL il_data[%0d]: got %h expected %h", got, m_resp_data, rdat[got]); end
                got++;
            end
        end
        checks++; if (got != 4) begin errors++; $display("[TB] FAIL il_count: got %0d responses expected 4", got); end
    endtask

    task automatic test_tag_full;
        do_reset();
        for (int i = 0; i < TD; i++) begin
            m_req_data[16:0] = make_cmd(OP_READ, 8'(i), 8'h00);
            m_req_valid      = 2'b01;
            tick();
            checks++; if (m_req_ready !== 2'b01) begin errors++; $display("[TB] FAIL tf_fill[%0d]: got %b expected 01", i, m_req_ready); end
            m_req_valid = 2'b00;
            tick();
        end
        m_req_data[16:0]  = make_cmd(OP_READ, 8'h55, 8'h00);
        m_req_data[33:17] = make_cmd(OP_WRITE, 8'h66, 8'h77);
        m_req_valid       = 2'b11;
        tick();
        checks++; if (m_req_ready !== 2'b10) begin errors++; $display("[TB] FAIL tf_write_ready: got %b expected 10", m_req_ready); end
        checks++; if (cmd_fifo_data !== 17'h16677) begin errors++; $display("[TB] FAIL tf_write_data: got %h expected 16677", cmd_fifo_data); end
        m_req_valid = 2'b01;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (m_req_ready !== 2'b00 || cmd_fifo_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL tf_read_held[%0d]: got ready=%b wr_en=%b expected 00/0", k, m_req_ready, cmd_fifo_wr_en); end
        end
        push_resp(8'h9C);
        tick();
        tick();
        checks++; if (m_req_ready !== 2'b00) begin errors++; $display("[TB] FAIL tf_still_held: got %b expected 00", m_req_ready); end
        tick();
        checks++; if (m_resp_valid !== 2'b01 || m_resp_data !== 8'h9C) begin errors++; $display("[TB] FAIL tf_resp: got valid=%b data=%h expected 01/9c", m_resp_valid, m_resp_data); end
        tick();
        checks++; if (m_req_ready !== 2'b01 || cmd_fifo_wr_en !== 1'b1) begin errors++; $display("[TB] FAIL tf_slot_freed: got ready=%b wr_en=%b expected 01/1", m_req_ready, cmd_fifo_wr_en); end
        checks++; if (cmd_fifo_data !== 17'h05500) begin errors++; $display("[TB] FAIL tf_read_data: got %h expected 05500", cmd_fifo_data); end
        m_req_valid = 2'b00;
        tick();
    endtask

    task automatic test_orphan;
        do_reset();
        push_resp(8'hEE);
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (resp_orphan_err !== 1'b1) begin errors++; $display("[TB] FAIL orphan_set[%0d]: got %b expected 1", k, resp_orphan_err); end
            checks++; if (resp_fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL orphan_no_pop[%0d]: got %b expected 0", k, resp_fifo_rd_en); end
        end
        rst = 1'b1;
        tick();
        checks++; if (resp_orphan_err !== 1'b0) begin errors++; $display("[TB] FAIL orphan_reset: got %b expected 0", resp_orphan_err); end
        rst = 1'b0;
        tick();
        checks++; if (resp_orphan_err !== 1'b0) begin errors++; $display("[TB] FAIL orphan_after_reset: got %b expected 0", resp_orphan_err); end
    endtask

    initial begin
        rst           = 1'b1;
        m_req_valid   = '0;
        m_req_data    = '0;
        cmd_fifo_full = 1'b0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_full_backpressure();
        test_interleaved_reads();
        test_tag_full();
        test_orphan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
